i2c_reg_bank: RTL and testbench

//  I2C target exposing NUM_REGS 8-bit registers behind one 7-bit device address.
//  The first byte after a write-address is the register pointer. Following data bytes

---
 rtl/i2c_reg_bank.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_reg_bank.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bank.sv
// I2C target with NUM_REGS byte registers behind one device address. The first data byte
// after a write address sets the register pointer; later data bytes write or read through it.
module i2c_reg_bank #(
    parameter int         FILTER_LEN = 4,
    parameter logic [6:0] DEV_ADDR   = 7'h70,
    parameter int         NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    output logic                  scl_o,
    output logic                  scl_t,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  sda_t,
    input  logic [8*NUM_REGS-1:0] reg_in,
    input  logic [NUM_REGS-1:0]   reg_latch,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  wr_strobe,
    output logic [7:0]            wr_addr,
    output logic                  rd_strobe,
    output logic [7:0]            rd_addr,
    output logic                  bus_active
);
    typedef enum logic [2:0] {
        IDLE, ADDRESS, ACK, WRITE_1, WRITE_2, READ_1, READ_2, READ_3
    } state_t;

    state_t                state_q, state_d;
    logic [FILTER_LEN-1:0] scl_sr_q, scl_sr_d, sda_sr_q, sda_sr_d;
    logic                  scl_f_q, scl_f_d, sda_f_q, sda_f_d, scl_p_q, sda_p_q;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d, ptr_q, ptr_d;
    logic                  rw_q, rw_d, first_q, first_d;
    logic                  sda_o_q, sda_o_d, bus_active_q, bus_active_d;
    logic                  wr_strobe_q, wr_strobe_d, rd_strobe_q, rd_strobe_d;
    logic [7:0]            wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [8*NUM_REGS-1:0] regs_q, regs_d;

    logic       scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;
    logic [7:0] in_byte, ptr_inc, rd_ptr, rd_data;
    logic       ptr_in_range, commit;

    // A filtered level only moves once the whole sample window agrees.
    always_comb begin
        scl_sr_d = FILTER_LEN'({scl_sr_q, scl_i});
        sda_sr_d = FILTER_LEN'({sda_sr_q, sda_i});
        scl_f_d  = scl_f_q;
        sda_f_d  = sda_f_q;
        if (&scl_sr_q)       scl_f_d = 1'b1;
        else if (~|scl_sr_q) scl_f_d = 1'b0;
        if (&sda_sr_q)       sda_f_d = 1'b1;
        else if (~|sda_sr_q) sda_f_d = 1'b0;
    end

    assign scl_rise   = scl_f_q & ~scl_p_q;
    assign scl_fall   = ~scl_f_q & scl_p_q;
    assign sda_rise   = sda_f_q & ~sda_p_q;
    assign sda_fall   = ~sda_f_q & sda_p_q;
    assign start_cond = sda_fall & scl_f_q;
    assign stop_cond  = sda_rise & scl_f_q;

    // READ_3 prefetches the byte at the incremented pointer for the next read byte.
    always_comb begin
        in_byte      = {shift_q[6:0], sda_f_q};
        ptr_inc      = (ptr_q == 8'(NUM_REGS - 1)) ? 8'd0 : ptr_q + 8'd1;
        ptr_in_range = (int'(ptr_q) < NUM_REGS);
        rd_ptr       = (state_q == READ_3) ? ptr_inc : ptr_q;
        rd_data      = 8'hFF;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_ptr == 8'(k)) rd_data = regs_q[8*k +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_cond) begin
            state_d = ADDRESS;
        end else if (stop_cond) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDRESS: if (scl_rise && bit_cnt_q == 3'd0)
                             state_d = (shift_q[6:0] == DEV_ADDR) ? ACK : IDLE;
                ACK:     if (scl_fall) state_d = rw_q ? READ_1 : WRITE_1;
                WRITE_1: if (scl_fall) state_d = WRITE_2;
                WRITE_2: if (scl_rise && bit_cnt_q == 3'd0) state_d = ACK;
                READ_1:  if (scl_fall && bit_cnt_q == 3'd0) state_d = READ_2;
                READ_2:  if (scl_fall) state_d = READ_3;
                READ_3:  if (scl_rise) state_d = sda_f_q ? IDLE : READ_1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        rw_d         = rw_q;
        first_d      = first_q;
        sda_o_d      = sda_o_q;
        bus_active_d = bus_active_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        rd_strobe_d  = 1'b0;
        rd_addr_d    = rd_addr_q;
        commit       = 1'b0;
        if (start_cond) begin
            bit_cnt_d    = 3'd7;
            sda_o_d      = 1'b1;
            first_d      = 1'b1;
            bus_active_d = 1'b1;
        end else if (stop_cond) begin
            sda_o_d      = 1'b1;
            bus_active_d = 1'b0;
        end else begin
            case (state_q)
                ADDRESS: if (scl_rise) begin
                    shift_d   = in_byte;
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) rw_d = sda_f_q;
                end
                ACK: if (scl_fall) begin
                    sda_o_d = 1'b0;
                    if (rw_q) begin
                        shift_d     = rd_data;
                        rd_strobe_d = 1'b1;
                        rd_addr_d   = ptr_q;
                        bit_cnt_d   = 3'd7;
                    end
                end
                WRITE_1: if (scl_fall) begin
                    sda_o_d   = 1'b1;
                    bit_cnt_d = 3'd7;
                end
                WRITE_2: if (scl_rise) begin
                    shift_d   = in_byte;
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        if (first_q) begin
                            ptr_d   = in_byte;
                            first_d = 1'b0;
                        end else begin
                            // Out-of-range bytes are still acknowledged, just dropped.
                            if (ptr_in_range) begin
                                commit      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                            end
                            ptr_d = ptr_inc;
                        end
                    end
                end
                READ_1: if (scl_fall) begin
                    sda_o_d   = shift_q[7];
                    shift_d   = {shift_q[6:0], 1'b1};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end
                READ_2: if (scl_fall) sda_o_d = 1'b1;
                READ_3: if (scl_rise && !sda_f_q) begin
                    ptr_d       = ptr_inc;
                    shift_d     = rd_data;
                    rd_strobe_d = 1'b1;
                    rd_addr_d   = ptr_inc;
                    bit_cnt_d   = 3'd7;
                end
                default: ;
            endcase
        end
    end

    // Host loads apply first so an I2C commit to the same register overrides them.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (reg_latch[k]) regs_d[8*k +: 8] = reg_in[8*k +: 8];
            if (commit && ptr_q == 8'(k)) regs_d[8*k +: 8] = in_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            scl_sr_q     <= '1;
            sda_sr_q     <= '1;
            scl_f_q      <= 1'b1;
            sda_f_q      <= 1'b1;
            scl_p_q      <= 1'b1;
            sda_p_q      <= 1'b1;
            bit_cnt_q    <= 3'd7;
            shift_q      <= 8'h00;
            ptr_q        <= 8'h00;
            rw_q         <= 1'b0;
            first_q      <= 1'b0;
            sda_o_q      <= 1'b1;
            bus_active_q <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= 8'h00;
            rd_strobe_q  <= 1'b0;
            rd_addr_q    <= 8'h00;
            regs_q       <= '0;
        end else begin
            state_q      <= state_d;
            scl_sr_q     <= scl_sr_d;
            sda_sr_q     <= sda_sr_d;
            scl_f_q      <= scl_f_d;
            sda_f_q      <= sda_f_d;
            scl_p_q      <= scl_f_q;
            sda_p_q      <= sda_f_q;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            rw_q         <= rw_d;
            first_q      <= first_d;
            sda_o_q      <= sda_o_d;
            bus_active_q <= bus_active_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            rd_strobe_q  <= rd_strobe_d;
            rd_addr_q    <= rd_addr_d;
            regs_q       <= regs_d;
        end
    end

    assign scl_o      = 1'b1;
    assign scl_t      = 1'b1;
    assign sda_o      = sda_o_q;
    assign sda_t      = sda_o_q;
    assign reg_out    = regs_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign rd_strobe  = rd_strobe_q;
    assign rd_addr    = rd_addr_q;
    assign bus_active = bus_active_q;
endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: bit-banged I2C controller on a wired-AND SDA line, with a
// register-array reference model of pointer, write, read and host-load behaviour.
module tb_i2c_reg_bank;
    localparam int         NUM_REGS = 16;
    localparam logic [6:0] DEV      = 7'h70;
    localparam int         Q        = 10;

    typedef struct {
        logic [6:0] addr7;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_read;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic scl_m, sda_m;
    logic scl_i, sda_i, scl_o, scl_t, sda_o, sda_t;
    logic [8*NUM_REGS-1:0] reg_in, reg_out;
    logic [NUM_REGS-1:0]   reg_latch;
    logic wr_strobe, rd_strobe, bus_active;
    logic [7:0] wr_addr, rd_addr;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_mem [256];
    logic [7:0] model_ptr;
    logic [7:0] wr_q[$], rd_q[$], exp_wr_q[$], exp_rd_q[$];
    logic [7:0] wdata_q[$], got_q[$], exp_data_q[$];
    vec_t       vecs [6];

    assign scl_i = scl_m;
    assign sda_i = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_reg_bank #(.FILTER_LEN(4), .DEV_ADDR(DEV), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .scl_i(scl_i), .scl_o(scl_o), .scl_t(scl_t),
        .sda_i(sda_i), .sda_o(sda_o), .sda_t(sda_t),
        .reg_in(reg_in), .reg_latch(reg_latch), .reg_out(reg_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .rd_strobe(rd_strobe), .rd_addr(rd_addr),
        .bus_active(bus_active)
    );

    always @(negedge clk) begin
        if (wr_strobe) wr_q.push_back(wr_addr);
        if (rd_strobe) rd_q.push_back(rd_addr);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] next_ptr(input logic [7:0] p);
        if (int'(p) == NUM_REGS - 1) return 8'd0;
        return p + 8'd1;
    endfunction

    function automatic logic [7:0] model_value(input logic [7:0] p);
        if (int'(p) < NUM_REGS) return model_mem[p];
        return 8'hFF;
    endfunction

    function automatic logic [8*NUM_REGS-1:0] model_flat();
        logic [8*NUM_REGS-1:0] f;
        for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = model_mem[k];
        return f;
    endfunction

    task automatic model_write(input logic [7:0] p);
        model_ptr = p;
        foreach (wdata_q[i]) begin
            if (int'(model_ptr) < NUM_REGS) begin
                model_mem[model_ptr] = wdata_q[i];
                exp_wr_q.push_back(model_ptr);
            end
            model_ptr = next_ptr(model_ptr);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 256; k++) model_mem[k] = 8'h00;
        model_ptr = 8'h00;
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        b = sda_i;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bit_v);
            b[i] = bit_v;
        end
        write_bit(~ack);
    endtask

    task automatic host_latch(input int k, input logic [7:0] v);
        reg_in[8*k +: 8] = v;
        reg_latch[k] = 1'b1;
        @(negedge clk);
        reg_latch[k] = 1'b0;
        model_mem[k] = v;
    endtask

    task automatic do_write(input logic [6:0] addr7, input logic [7:0] p, output logic all_ack);
        logic ack;
        i2c_start();
        write_byte({addr7, 1'b0}, ack);
        all_ack = ack;
        if (ack) begin
            write_byte(p, ack);
            all_ack &= ack;
            foreach (wdata_q[i]) begin
                write_byte(wdata_q[i], ack);
                all_ack &= ack;
            end
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n,
                           output logic all_ack, output logic probe);
        logic ack;
        logic [7:0] b;
        got_q.delete();
        all_ack = 1'b1;
        if (set_ptr) begin
            i2c_start();
            write_byte({DEV, 1'b0}, ack);
            all_ack &= ack;
            write_byte(p, ack);
            all_ack &= ack;
        end
        i2c_start();
        write_byte({DEV, 1'b1}, ack);
        all_ack &= ack;
        for (int i = 0; i < n; i++) begin
            read_byte(b, i < n - 1);
            got_q.push_back(b);
        end
        read_bit(probe);
        i2c_stop();
    endtask

    task automatic check_strobes(input string name);
        check_output({name, "_wr_count"}, 128'(wr_q.size()), 128'(exp_wr_q.size()));
        check_output({name, "_rd_count"}, 128'(rd_q.size()), 128'(exp_rd_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++)
            check_output({name, "_wr_addr"}, 128'(wr_q[i]), 128'(exp_wr_q[i]));
        for (int i = 0; i < rd_q.size() && i < exp_rd_q.size(); i++)
            check_output({name, "_rd_addr"}, 128'(rd_q[i]), 128'(exp_rd_q[i]));
        wr_q.delete();
        rd_q.delete();
        exp_wr_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic read_and_check(input string name, input logic set_ptr,
                                  input logic [7:0] p, input int n);
        logic all_ack, probe;
        exp_data_q.delete();
        if (set_ptr) model_ptr = p;
        for (int i = 0; i < n; i++) begin
            exp_data_q.push_back(model_value(model_ptr));
            exp_rd_q.push_back(model_ptr);
            if (i < n - 1) model_ptr = next_ptr(model_ptr);
        end
        do_read(set_ptr, p, n, all_ack, probe);
        check_output({name, "_ack"}, 128'(all_ack), 128'(1'b1));
        check_output({name, "_idle_after_nack"}, 128'(probe), 128'(1'b1));
        for (int i = 0; i < n; i++)
            check_output({name, "_data"}, 128'(got_q[i]), 128'(exp_data_q[i]));
        check_strobes(name);
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic ack;
        wdata_q.delete();
        wdata_q.push_back(v.data);
        do_write(v.addr7, v.ptr, ack);
        check_output("vec_ack", 128'(ack), 128'(v.exp_ack));
        if (v.addr7 == DEV) model_write(v.ptr);
        check_strobes("vec_write");
        read_and_check("vec_read", 1'b1, v.ptr, 1);
        check_output("vec_read_table", 128'(got_q[0]), 128'(v.exp_read));
        check_output("vec_regs", 128'(reg_out), 128'(model_flat()));
    endtask

    task automatic collision_write();
        logic ack, seen;
        logic [7:0] d;
        d = 8'h22;
        i2c_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h04, ack);
        for (int i = 7; i >= 1; i--) write_bit(d[i]);
        sda_m = d[0];
        wait_q();
        reg_in[8*4 +: 8] = 8'h77;
        reg_in[8*6 +: 8] = 8'h66;
        reg_latch[4] = 1'b1;
        reg_latch[6] = 1'b1;
        scl_m = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2*Q; i++) begin
            @(negedge clk);
            if (wr_strobe && !seen) begin
                seen = 1'b1;
                reg_latch = '0;
            end
        end
        reg_latch = '0;
        scl_m = 1'b0;
        wait_q();
        read_bit(ack);
        i2c_stop();
        check_output("t5_strobe_seen", 128'(seen), 128'(1'b1));
        check_output("t5_data_ack", 128'(ack), 128'(1'b0));
        model_mem[6] = 8'h66;
        wdata_q.delete();
        wdata_q.push_back(8'h22);
        model_write(8'h04);
        check_output("t5_reg4", 128'(reg_out[8*4 +: 8]), 128'(8'h22));
        check_output("t5_regs", 128'(reg_out), 128'(model_flat()));
        check_strobes("t5");
    endtask

    task automatic reset_mid_read();
        logic ack, b, all_one;
        host_latch(3, 8'h00);
        i2c_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte({DEV, 1'b1}, ack);
        read_bit(b);
        read_bit(b);
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        check_output("t6_driving_before_reset", 128'(sda_o), 128'(1'b0));
        rst = 1'b1;
        #1;
        check_output("t6_sda_released", 128'(sda_o), 128'(1'b1));
        check_output("t6_sda_t_released", 128'(sda_t), 128'(1'b1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
        all_one = 1'b1;
        for (int i = 0; i < 6; i++) begin
            read_bit(b);
            all_one &= b;
        end
        i2c_stop();
        check_output("t6_bus_ignored", 128'(all_one), 128'(1'b1));
        model_reset();
        wr_q.delete();
        rd_q.delete();
        exp_wr_q.delete();
        exp_rd_q.delete();
        check_output("t6_regs_cleared", 128'(reg_out), 128'(0));
        host_latch(0, 8'hAB);
        read_and_check("t6_ptr_zero", 1'b0, 8'h00, 1);
        check_output("t6_read_reg0", 128'(got_q[0]), 128'(8'hAB));
    endtask

    initial begin
        logic ack;
        logic [7:0] p;
        int kind, n;

        scl_m = 1'b1;
        sda_m = 1'b1;
        reg_in = '0;
        reg_latch = '0;
        rst = 1'b1;
        model_reset();
        vecs[0] = '{7'h70, 8'h03, 8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{7'h70, 8'h00, 8'h3C, 1'b1, 8'h3C};
        vecs[2] = '{7'h70, 8'h0F, 8'hC3, 1'b1, 8'hC3};
        vecs[3] = '{7'h71, 8'h05, 8'h99, 1'b0, 8'h00};
        vecs[4] = '{7'h70, 8'h20, 8'h11, 1'b1, 8'hFF};
        vecs[5] = '{7'h38, 8'h02, 8'h7E, 1'b0, 8'h00};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_output("reset_sda_o", 128'(sda_o), 128'(1'b1));
        check_output("reset_sda_t", 128'(sda_t), 128'(1'b1));
        check_output("reset_scl_o", 128'(scl_o), 128'(1'b1));
        check_output("reset_scl_t", 128'(scl_t), 128'(1'b1));
        check_output("reset_regs", 128'(reg_out), 128'(0));
        check_output("reset_wr_strobe", 128'(wr_strobe), 128'(1'b0));
        check_output("reset_rd_strobe", 128'(rd_strobe), 128'(1'b0));
        check_output("reset_bus_active", 128'(bus_active), 128'(1'b0));

        i2c_start();
        check_output("bus_active_after_start", 128'(bus_active), 128'(1'b1));
        i2c_stop();
        check_output("bus_active_after_stop", 128'(bus_active), 128'(1'b0));

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Two data bytes: both commit at consecutive pointers, then read at the resulting ptr.
        wdata_q.delete();
        wdata_q.push_back(8'hA5);
        wdata_q.push_back(8'h5A);
        do_write(DEV, 8'h03, ack);
        check_output("t1_ack", 128'(ack), 128'(1'b1));
        model_write(8'h03);
        check_strobes("t1");
        check_output("t1_reg3", 128'(reg_out[8*3 +: 8]), 128'(8'hA5));
        check_output("t1_reg4", 128'(reg_out[8*4 +: 8]), 128'(8'h5A));
        check_output("t1_ptr_is_5", 128'(model_ptr), 128'(8'h05));
        read_and_check("t1_read_at_ptr", 1'b0, 8'h00, 1);

        host_latch(2, 8'h00);
        read_and_check("t2_wrap_read", 1'b1, 8'h0F, 3);

        // Pointer 0xFF discards its byte and wraps mod 256 to register 0.
        wdata_q.delete();
        wdata_q.push_back(8'h10);
        wdata_q.push_back(8'h20);
        do_write(DEV, 8'hFF, ack);
        check_output("ff_wrap_ack", 128'(ack), 128'(1'b1));
        model_write(8'hFF);
        check_strobes("ff_wrap");
        check_output("ff_wrap_regs", 128'(reg_out), 128'(model_flat()));

        collision_write();

        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 2);
            p = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255))
                                             : 8'($urandom_range(0, 15));
            n = $urandom_range(1, 3);
            if (kind == 0) begin
                wdata_q.delete();
                for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom));
                do_write(DEV, p, ack);
                check_output("rand_write_ack", 128'(ack), 128'(1'b1));
                model_write(p);
                check_strobes("rand_write");
            end else if (kind == 1) begin
                read_and_check("rand_read", 1'($urandom_range(0, 1)), p, n);
            end else begin
                host_latch($urandom_range(0, NUM_REGS - 1), 8'($urandom));
            end
            check_output("rand_regs", 128'(reg_out), 128'(model_flat()));
        end

        reset_mid_read();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
